// File: rtl/data_path_if.sv
// Control strobes, memory data and observation outputs of the single-bus datapath.
// The control unit (or bench) holds the master side; the datapath is the slave.
interface data_path_if #(
  parameter int WIDTH = 32
);
  logic             R1in, R2in, R3in, R4in;
  logic             R1out, R2out, R3out, R4out;
  logic             PCin, PCout;
  logic             MDRin, MDRout, MD_read;
  logic [WIDTH-1:0] Mdatain;
  logic             MARin, IRin, Yin;
  logic             Zlowin, Zlowout;
  logic             IncPC;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] bus_out;
  logic [WIDTH-1:0] mar_out;
  logic [WIDTH-1:0] ir_out;

  // Strobes are level signals sampled on the rising clock edge; there is no
  // valid/ready pairing, a strobe high before the edge means "do it this cycle".
  modport master (
    output R1in, R2in, R3in, R4in, R1out, R2out, R3out, R4out,
    output PCin, PCout, MDRin, MDRout, MD_read, Mdatain,
    output MARin, IRin, Yin, Zlowin, Zlowout, IncPC, alu_op,
    input  bus_out, mar_out, ir_out
  );

  modport slave (
    input  R1in, R2in, R3in, R4in, R1out, R2out, R3out, R4out,
    input  PCin, PCout, MDRin, MDRout, MD_read, Mdatain,
    input  MARin, IRin, Yin, Zlowin, Zlowout, IncPC, alu_op,
    output bus_out, mar_out, ir_out
  );
endinterface

// File: rtl/data_path.sv
// Single-bus CPU datapath: R1-R4, PC, IR, MAR, MDR, Y and Zlow around one shared bus.
// The ALU computes from A = Y and B = bus, and its result is captured in Zlow.
module data_path #(
  parameter int WIDTH = 32
) (
  input  logic        clock,
  input  logic        clear,
  data_path_if.slave  dp
);
  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_q [4];
  logic [WIDTH-1:0] r_d [4];
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [WIDTH-1:0] mar_q, mar_d;
  logic [WIDTH-1:0] mdr_q, mdr_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] zlow_q, zlow_d;

  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   shamt;
  logic [3:0]       r_in;

  assign r_in  = {dp.R4in, dp.R3in, dp.R2in, dp.R1in};
  assign shamt = bus[SHW-1:0];

  // Fixed-priority bus mux; the first matching driver wins.
  always_comb begin
    bus = '0;
    if (dp.Zlowout)     bus = zlow_q;
    else if (dp.MDRout) bus = mdr_q;
    else if (dp.PCout)  bus = pc_q;
    else if (dp.R1out)  bus = r_q[0];
    else if (dp.R2out)  bus = r_q[1];
    else if (dp.R3out)  bus = r_q[2];
    else if (dp.R4out)  bus = r_q[3];
  end

  always_comb begin
    alu_res = '0;
    case (dp.alu_op)
      4'd0:    alu_res = y_q + bus;
      4'd1:    alu_res = y_q - bus;
      4'd2:    alu_res = y_q & bus;
      4'd3:    alu_res = y_q | bus;
      4'd4:    alu_res = y_q >> shamt;
      4'd5:    alu_res = y_q << shamt;
      4'd6:    alu_res = '0 - bus;
      4'd7:    alu_res = ~bus;
      default: alu_res = '0;
    endcase
    if (dp.IncPC) alu_res = bus + WIDTH'(1);
  end

  always_comb begin
    for (int i = 0; i < 4; i++) r_d[i] = r_in[i] ? bus : r_q[i];
    pc_d   = dp.PCin   ? bus : pc_q;
    ir_d   = dp.IRin   ? bus : ir_q;
    mar_d  = dp.MARin  ? bus : mar_q;
    y_d    = dp.Yin    ? bus : y_q;
    zlow_d = dp.Zlowin ? alu_res : zlow_q;
    mdr_d  = mdr_q;
    if (dp.MDRin) mdr_d = dp.MD_read ? dp.Mdatain : bus;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < 4; i++) r_q[i] <= '0;
      pc_q   <= '0;
      ir_q   <= '0;
      mar_q  <= '0;
      mdr_q  <= '0;
      y_q    <= '0;
      zlow_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) r_q[i] <= r_d[i];
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      mar_q  <= mar_d;
      mdr_q  <= mdr_d;
      y_q    <= y_d;
      zlow_q <= zlow_d;
    end
  end

  // Observation outputs are forced to zero for the whole time clear is held low.
  assign dp.bus_out = clear ? bus : '0;
  assign dp.mar_out = mar_q;
  assign dp.ir_out  = ir_q;
endmodule

// File: tb/tb_data_path.sv
// Bench for data_path: directed bus/load sequences, an ALU vector table,
// and randomized ALU and bus-priority traffic checked against a reference model.
module tb_data_path;
  logic clock = 1'b0;
  logic clear = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  data_path_if #(.WIDTH(32)) dif ();
  data_path #(.WIDTH(32)) u_dut (.clock(clock), .clear(clear), .dp(dif.slave));

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  op;
    logic        inc;
    logic [31:0] y;
    logic [31:0] b;
    logic [31:0] exp;
  } alu_vec_t;

  task automatic idle();
    {dif.R1in, dif.R2in, dif.R3in, dif.R4in} = '0;
    {dif.R1out, dif.R2out, dif.R3out, dif.R4out} = '0;
    {dif.PCin, dif.PCout, dif.MDRin, dif.MDRout, dif.MD_read} = '0;
    {dif.MARin, dif.IRin, dif.Yin, dif.Zlowin, dif.Zlowout, dif.IncPC} = '0;
    dif.alu_op = 4'd0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_rin(input int k);
    case (k)
      1: dif.R1in = 1'b1;
      2: dif.R2in = 1'b1;
      3: dif.R3in = 1'b1;
      default: dif.R4in = 1'b1;
    endcase
  endtask

  task automatic set_rout(input int k);
    case (k)
      1: dif.R1out = 1'b1;
      2: dif.R2out = 1'b1;
      3: dif.R3out = 1'b1;
      default: dif.R4out = 1'b1;
    endcase
  endtask

  task automatic mdr_load(input logic [31:0] v);
    dif.Mdatain = v;
    dif.MD_read = 1'b1;
    dif.MDRin   = 1'b1;
    tick();
  endtask

  task automatic reg_from_mdr(input int k, input logic [31:0] v);
    mdr_load(v);
    dif.MDRout = 1'b1;
    set_rin(k);
    tick();
  endtask

  task automatic read_reg(input int k, input string name, input logic [31:0] exp);
    set_rout(k);
    #1;
    check(name, dif.bus_out, exp);
    idle();
  endtask

  // Reference ALU: shifts expressed as multiply/divide by a power of two.
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic inc,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint unsigned pw;
    pw = 64'd1 << (b % 32);
    if (inc) return 32'(64'(b) + 64'd1);
    case (op)
      4'd0: return 32'(64'(a) + 64'(b));
      4'd1: return 32'(64'h1_0000_0000 + 64'(a) - 64'(b));
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: begin p = 64'(a) / pw; return p[31:0]; end
      4'd5: begin p = 64'(a) * pw; return p[31:0]; end
      4'd6: return 32'(64'h1_0000_0000 - 64'(b));
      4'd7: return 32'hFFFF_FFFF ^ b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic run_alu(input string name, input logic [3:0] op, input logic inc,
                         input logic [31:0] y, input logic [31:0] b, input logic [31:0] exp);
    mdr_load(y);
    dif.MDRout = 1'b1;
    dif.Yin    = 1'b1;
    tick();
    mdr_load(b);
    dif.MDRout = 1'b1;
    dif.alu_op = op;
    dif.IncPC  = inc;
    dif.Zlowin = 1'b1;
    tick();
    dif.Zlowout = 1'b1;
    #1;
    check(name, dif.bus_out, exp);
    idle();
  endtask

  alu_vec_t    vecs[$];
  logic [31:0] model_r [4];
  logic [31:0] model_mdr;
  logic [31:0] v, exp_bus;
  logic [4:0]  mask;
  logic [3:0]  rop;
  logic        rinc;

  initial begin
    idle();
    dif.Mdatain = '0;

    // Reset state and async clear over loaded registers.
    repeat (2) @(posedge clock);
    #1;
    check("rst_bus", dif.bus_out, 32'd0);
    check("rst_mar", dif.mar_out, 32'd0);
    check("rst_ir", dif.ir_out, 32'd0);
    clear = 1'b1;
    for (int k = 1; k <= 4; k++) reg_from_mdr(k, 32'hA0 + 32'(k));
    mdr_load(32'h5A5A);
    dif.MDRout = 1'b1; dif.MARin = 1'b1; dif.IRin = 1'b1;
    tick();
    check("pre_mar", dif.mar_out, 32'h5A5A);
    check("pre_ir", dif.ir_out, 32'h5A5A);
    read_reg(3, "pre_r3", 32'hA3);
    clear = 1'b0;
    #1;
    check("clr_mar", dif.mar_out, 32'd0);
    check("clr_ir", dif.ir_out, 32'd0);
    dif.R1out = 1'b1;
    #1;
    check("clr_bus", dif.bus_out, 32'd0);
    idle();
    mdr_load(32'hDEAD);
    clear = 1'b1;
    for (int k = 1; k <= 4; k++) read_reg(k, $sformatf("rel_r%0d", k), 32'd0);
    dif.MDRout = 1'b1;
    #1;
    check("rel_mdr", dif.bus_out, 32'd0);
    idle();

    // Memory load path.
    reg_from_mdr(2, 32'h12);
    reg_from_mdr(3, 32'h04);
    reg_from_mdr(1, 32'h18);
    read_reg(2, "load_r2", 32'h12);
    read_reg(3, "load_r3", 32'h04);
    read_reg(1, "load_r1", 32'h18);

    // Fetch: MAR <- PC, Zlow <- PC+1, PC <- Zlow, IR <- memory.
    dif.PCout = 1'b1; dif.MARin = 1'b1; dif.IncPC = 1'b1; dif.Zlowin = 1'b1;
    tick();
    check("fetch_mar", dif.mar_out, 32'd0);
    dif.Zlowout = 1'b1;
    #1;
    check("fetch_zlow", dif.bus_out, 32'd1);
    dif.PCin = 1'b1;
    tick();
    dif.PCout = 1'b1;
    #1;
    check("fetch_pc", dif.bus_out, 32'd1);
    idle();
    mdr_load(32'h8);
    dif.MDRout = 1'b1; dif.IRin = 1'b1;
    tick();
    check("fetch_ir", dif.ir_out, 32'h8);

    // New MDR value is not on the bus until the cycle after MDRin.
    dif.Mdatain = 32'h55; dif.MD_read = 1'b1; dif.MDRin = 1'b1; dif.MDRout = 1'b1;
    #1;
    check("mdr_old", dif.bus_out, 32'h8);
    tick();
    dif.MDRout = 1'b1;
    #1;
    check("mdr_new", dif.bus_out, 32'h55);
    idle();

    // SHR 0x12 >> 4 into R1.
    dif.R2out = 1'b1; dif.Yin = 1'b1;
    tick();
    dif.R3out = 1'b1; dif.alu_op = 4'd4; dif.Zlowin = 1'b1;
    tick();
    dif.Zlowout = 1'b1;
    #1;
    check("shr_zlow", dif.bus_out, 32'h1);
    dif.R1in = 1'b1;
    tick();
    read_reg(1, "shr_r1", 32'h1);

    // Zlow drives and loads in one cycle: bus shows old, Zlow takes Y+old.
    dif.Zlowout = 1'b1; dif.Zlowin = 1'b1; dif.alu_op = 4'd0;
    #1;
    check("zz_old", dif.bus_out, 32'h1);
    tick();
    dif.Zlowout = 1'b1;
    #1;
    check("zz_new", dif.bus_out, 32'h13);
    idle();

    // Priority between simultaneous drivers.
    dif.R1out = 1'b1; dif.R2out = 1'b1;
    #1;
    check("prio_r1r2", dif.bus_out, 32'h1);
    dif.Zlowout = 1'b1; dif.PCout = 1'b1;
    #1;
    check("prio_zlow", dif.bus_out, 32'h13);
    idle();

    // ALU vector table.
    vecs.push_back('{4'd0, 1'b0, 32'hF, 32'h3, 32'h12});
    vecs.push_back('{4'd1, 1'b0, 32'hF, 32'h3, 32'hC});
    vecs.push_back('{4'd2, 1'b0, 32'hF, 32'h3, 32'h3});
    vecs.push_back('{4'd3, 1'b0, 32'hF, 32'h3, 32'hF});
    vecs.push_back('{4'd5, 1'b0, 32'hF, 32'h3, 32'h78});
    vecs.push_back('{4'd6, 1'b0, 32'hF, 32'h3, 32'hFFFF_FFFD});
    vecs.push_back('{4'd7, 1'b0, 32'hF, 32'h3, 32'hFFFF_FFFC});
    vecs.push_back('{4'd1, 1'b0, 32'h0, 32'h1, 32'hFFFF_FFFF});
    vecs.push_back('{4'd3, 1'b1, 32'h7, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{4'd4, 1'b0, 32'hF0, 32'h24, 32'hF});
    vecs.push_back('{4'd5, 1'b0, 32'h1, 32'h3F, 32'h8000_0000});
    vecs.push_back('{4'd9, 1'b0, 32'hF, 32'h3, 32'h0});
    vecs.push_back('{4'd15, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0});
    foreach (vecs[i])
      run_alu($sformatf("alu_tab%0d", i), vecs[i].op, vecs[i].inc, vecs[i].y, vecs[i].b, vecs[i].exp);

    // Randomized ALU against the reference model.
    for (int i = 0; i < 60; i++) begin
      rop  = 4'($urandom_range(0, 15));
      rinc = ($urandom_range(0, 7) == 0);
      v    = $urandom;
      exp_bus = $urandom;
      run_alu($sformatf("alu_rnd%0d_op%0d", i, rop), rop, rinc, v, exp_bus,
              alu_ref(rop, rinc, v, exp_bus));
    end

    // Randomized register traffic and multi-driver priority.
    for (int k = 1; k <= 4; k++) begin
      model_r[k-1] = $urandom;
      reg_from_mdr(k, model_r[k-1]);
    end
    model_mdr = model_r[3];
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        int k;
        k = $urandom_range(1, 4);
        model_r[k-1] = $urandom;
        model_mdr = model_r[k-1];
        reg_from_mdr(k, model_r[k-1]);
      end
      mask = 5'($urandom_range(0, 31));
      exp_bus = 32'd0;
      begin
        logic [31:0] srcs[$];
        srcs = '{};
        if (mask[0]) srcs.push_back(model_mdr);
        for (int k = 1; k <= 4; k++) if (mask[k]) srcs.push_back(model_r[k-1]);
        if (srcs.size() > 0) exp_bus = srcs[0];
      end
      dif.MDRout = mask[0];
      dif.R1out = mask[1]; dif.R2out = mask[2]; dif.R3out = mask[3]; dif.R4out = mask[4];
      #1;
      check($sformatf("prio_rnd%0d_m%02h", i, mask), dif.bus_out, exp_bus);
      idle();
    end

    // Clear in the middle of a sequence wipes everything.
    dif.R1out = 1'b1; dif.Yin = 1'b1;
    #2;
    clear = 1'b0;
    #1;
    check("mid_bus", dif.bus_out, 32'd0);
    tick();
    clear = 1'b1;
    read_reg(1, "mid_r1", 32'd0);
    read_reg(4, "mid_r4", 32'd0);
    dif.Zlowout = 1'b1;
    #1;
    check("mid_zlow", dif.bus_out, 32'd0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
